// File: rtl/oam_sprite_evaluator_if.sv
// Signal bundle between the sprite evaluator and its surroundings (OAM read port,
// line-list read port, control and status).
interface oam_sprite_evaluator_if #(
  parameter int NUM_ENTRIES = 64,
  parameter int MAX_SPRITES = 8
);
  localparam int AW = $clog2(NUM_ENTRIES);
  localparam int LW = $clog2(MAX_SPRITES);
  localparam int CW = $clog2(MAX_SPRITES + 1);

  // Handshake: start is a one-cycle request that is taken only while busy is low
  // (IDLE); there is no back-pressure, and a request seen while busy is dropped.
  // done is a one-cycle completion pulse, after which the results hold until the
  // next accepted start.
  logic          start;
  logic [7:0]    scanline;
  logic          tall_sprites;
  logic [AW-1:0] oam_read_addr;
  logic [31:0]   oam_read_data;
  logic [LW-1:0] list_rd_addr;
  logic [31:0]   list_rd_data;
  logic [CW-1:0] sprite_count;
  logic          sprite_zero;
  logic          overflow;
  logic          busy;
  logic          done;
  logic [1:0]    state;

  modport master (
    output start, scanline, tall_sprites, oam_read_data, list_rd_addr,
    input  oam_read_addr, list_rd_data, sprite_count, sprite_zero, overflow,
           busy, done, state
  );

  modport slave (
    input  start, scanline, tall_sprites, oam_read_data, list_rd_addr,
    output oam_read_addr, list_rd_data, sprite_count, sprite_zero, overflow,
           busy, done, state
  );
endinterface

// File: rtl/oam_sprite_evaluator.sv
// OAM scanner: walks every OAM entry once per start pulse and collects up to
// MAX_SPRITES sprites covering the requested scanline into a small line list.
module oam_sprite_evaluator #(
  parameter int NUM_ENTRIES = 64,
  parameter int MAX_SPRITES = 8
) (
  input logic                    clk,
  input logic                    reset,
  oam_sprite_evaluator_if.slave  bus
);
  localparam int AW = $clog2(NUM_ENTRIES);
  localparam int LW = $clog2(MAX_SPRITES);
  localparam int CW = $clog2(MAX_SPRITES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    line_q, line_d;
  logic          tall_q, tall_d;
  logic [CW-1:0] count_q, count_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   list_q [MAX_SPRITES];
  logic [31:0]   list_d [MAX_SPRITES];

  logic [7:0] oam_y;
  logic [8:0] diff;
  logic [8:0] height;
  logic       hit;
  logic       list_full;
  logic       last_entry;

  // A sprite above the line gives a negative diff (bit 8 set), so it never wraps.
  assign oam_y      = bus.oam_read_data[31:24];
  assign diff       = {1'b0, line_q} - {1'b0, oam_y};
  assign height     = tall_q ? 9'd16 : 9'd8;
  assign hit        = !diff[8] && (diff < height);
  assign list_full  = (count_q == CW'(MAX_SPRITES));
  assign last_entry = (addr_q == AW'(NUM_ENTRIES - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    line_d  = line_q;
    tall_d  = tall_q;
    count_d = count_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    list_d  = list_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          line_d  = bus.scanline;
          tall_d  = bus.tall_sprites;
          count_d = '0;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          addr_d  = '0;
          for (int i = 0; i < MAX_SPRITES; i++) list_d[i] = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        addr_d = addr_q + AW'(1);
        if (last_entry) begin
          addr_d  = '0;
          state_d = ST_DONE;
        end
        if (hit) begin
          if (list_full) begin
            // One hit too many: the line is already full, stop scanning early.
            ovf_d   = 1'b1;
            addr_d  = '0;
            state_d = ST_DONE;
          end else begin
            list_d[count_q[LW-1:0]] = {diff[7:0], bus.oam_read_data[23:0]};
            count_d = count_q + CW'(1);
            if (addr_q == '0) zero_d = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      line_q  <= '0;
      tall_q  <= 1'b0;
      count_q <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < MAX_SPRITES; i++) list_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      tall_q  <= tall_d;
      count_q <= count_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < MAX_SPRITES; i++) list_q[i] <= list_d[i];
    end
  end

  // Entries past the valid count read as zero even if stale data were present.
  assign bus.list_rd_data  = (CW'(bus.list_rd_addr) < count_q) ? list_q[bus.list_rd_addr] : '0;
  assign bus.oam_read_addr = addr_q;
  assign bus.sprite_count  = count_q;
  assign bus.sprite_zero   = zero_q;
  assign bus.overflow      = ovf_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.done          = (state_q == ST_DONE);
  assign bus.state         = state_q;
endmodule

// File: tb/tb_oam_sprite_evaluator.sv
// Directed bench for the OAM sprite evaluator: a per-scan model computes which
// sprites hit the line, and a per-cycle compare process checks busy/done/addr.
`timescale 1ns/1ps
module tb_oam_sprite_evaluator;
  logic clk = 1'b0;
  logic reset;

  oam_sprite_evaluator_if bus ();

  oam_sprite_evaluator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  logic [31:0] oam [64];
  assign bus.oam_read_data = oam[bus.oam_read_addr];

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  int exp_cnt;
  int exp_lat;
  bit exp_zero;
  bit exp_ovf;

  bit mon_en = 1'b0;
  int mon_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle c after the start edge: busy until the done cycle, done only there,
  // and during the scan the OAM entry being read is entry c.
  always @(negedge clk) begin
    if (mon_en) begin
      chk($sformatf("busy@%0d", mon_cyc), 32'(bus.busy), 32'(mon_cyc <= exp_lat));
      chk($sformatf("done@%0d", mon_cyc), 32'(bus.done), 32'(mon_cyc == exp_lat));
      if (mon_cyc < exp_lat)
        chk($sformatf("oam_addr@%0d", mon_cyc), 32'(bus.oam_read_addr), 32'(mon_cyc));
      mon_cyc++;
    end
  end

  task automatic fill_miss();
    for (int i = 0; i < 64; i++) oam[i] = {8'hF0, 8'(i), 8'(i ^ 8'h5A), 8'(i * 3)};
  endtask

  task automatic setup_t2();
    fill_miss();
    oam[0] = 32'h0A112233;
    oam[5] = {8'd20, 24'hABCDEF};
  endtask

  task automatic setup_t3();
    fill_miss();
    for (int k = 0; k < 10; k++) begin
      int e;
      e = (k == 0) ? 3 : 5 + 2 * k;
      oam[e] = {8'd50, 8'(e), 8'h40, 8'(e + 1)};
    end
  endtask

  task automatic model(input logic [7:0] line, input bit tall);
    int h;
    h = tall ? 16 : 8;
    exp_q.delete();
    repeat (8) exp_q.push_back(32'h0);
    exp_cnt = 0; exp_zero = 0; exp_ovf = 0; exp_lat = 64;
    for (int i = 0; i < 64; i++) begin
      int r;
      r = int'(line) - int'(oam[i][31:24]);
      if (r >= 0 && r < h) begin
        if (exp_cnt == 8) begin
          exp_ovf = 1; exp_lat = i + 1;
          break;
        end
        exp_q[exp_cnt] = {8'(r), oam[i][23:0]};
        if (i == 0) exp_zero = 1;
        exp_cnt++;
      end
    end
  endtask

  // Asserts reset partway through a cycle and expects every output cleared at once.
  task automatic reset_check(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "/busy"},  32'(bus.busy), 32'h0);
    chk({tag, "/done"},  32'(bus.done), 32'h0);
    chk({tag, "/count"}, 32'(bus.sprite_count), 32'h0);
    chk({tag, "/zero"},  32'(bus.sprite_zero), 32'h0);
    chk({tag, "/ovf"},   32'(bus.overflow), 32'h0);
    chk({tag, "/addr"},  32'(bus.oam_read_addr), 32'h0);
    for (int i = 0; i < 8; i++) begin
      bus.list_rd_addr = 3'(i);
      #1 chk($sformatf("%s/list%0d", tag, i), bus.list_rd_data, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_scan(input logic [7:0] line, input bit tall, input int poke_at,
                          input int reset_at, input string tag);
    model(line, tall);
    bus.scanline     = line;
    bus.tall_sprites = tall;
    bus.start        = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    mon_cyc   = 0;
    mon_en    = 1'b1;
    for (int c = 0; c <= exp_lat + 1; c++) begin
      @(negedge clk);
      #1;
      if (c == 0) begin
        chk({tag, "/clr_count"}, 32'(bus.sprite_count), 32'h0);
        for (int i = 0; i < 8; i++) begin
          bus.list_rd_addr = 3'(i);
          #1 chk($sformatf("%s/clr_list%0d", tag, i), bus.list_rd_data, 32'h0);
        end
      end
      if (c == poke_at) begin
        bus.start    = 1'b1;
        bus.scanline = line ^ 8'h06;
      end else if (c == poke_at + 1) begin
        bus.start = 1'b0;
      end
      if (c == reset_at) begin
        mon_en = 1'b0;
        reset_check({tag, "/rst"});
        return;
      end
    end
    mon_en = 1'b0;
    chk({tag, "/count"}, 32'(bus.sprite_count), 32'(exp_cnt));
    chk({tag, "/zero"},  32'(bus.sprite_zero), 32'(exp_zero));
    chk({tag, "/ovf"},   32'(bus.overflow), 32'(exp_ovf));
    for (int i = 0; i < 8; i++) begin
      bus.list_rd_addr = 3'(i);
      #0.5 chk($sformatf("%s/list%0d", tag, i), bus.list_rd_data, exp_q[i]);
    end
  endtask

  task automatic lit_list(input string name, input int idx, input logic [31:0] exp);
    @(negedge clk);
    bus.list_rd_addr = 3'(idx);
    #1 chk(name, bus.list_rd_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.scanline = '0;
    bus.tall_sprites = 1'b0;
    bus.list_rd_addr = '0;
    fill_miss();
    repeat (2) @(negedge clk);
    #1;
    chk("por/busy",  32'(bus.busy), 32'h0);
    chk("por/done",  32'(bus.done), 32'h0);
    chk("por/count", 32'(bus.sprite_count), 32'h0);
    chk("por/addr",  32'(bus.oam_read_addr), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Single hit on entry 0, full 64-cycle scan.
    setup_t2();
    run_scan(8'd12, 1'b0, -1, -1, "t2");
    chk("t2/model_lat", 32'(exp_lat), 32'd64);
    chk("t2/model_cnt", 32'(exp_cnt), 32'd1);
    lit_list("t2/lit_list0", 0, 32'h02112233);
    chk("t2/lit_zero", 32'(bus.sprite_zero), 32'h1);

    // Async reset with results held in IDLE.
    @(negedge clk);
    reset_check("t1");

    // Ten hits: overflow on the ninth, early exit.
    setup_t3();
    run_scan(8'd50, 1'b0, -1, -1, "t3");
    chk("t3/model_lat", 32'(exp_lat), 32'd22);
    lit_list("t3/lit_list7", 7, {8'd0, 8'd19, 8'h40, 8'd20});
    chk("t3/lit_ovf", 32'(bus.overflow), 32'h1);

    // Height boundaries and no vertical wrap.
    fill_miss();
    oam[0] = {8'd100, 24'h010203};
    @(negedge clk);
    run_scan(8'd107, 1'b0, -1, -1, "t4a");
    lit_list("t4a/lit_list0", 0, 32'h07010203);
    @(negedge clk);
    run_scan(8'd108, 1'b0, -1, -1, "t4b");
    chk("t4b/lit_count", 32'(bus.sprite_count), 32'h0);
    run_scan(8'd115, 1'b1, -1, -1, "t4c");
    lit_list("t4c/lit_list0", 0, 32'h0F010203);
    @(negedge clk);
    run_scan(8'd116, 1'b1, -1, -1, "t4d");
    chk("t4d/lit_count", 32'(bus.sprite_count), 32'h0);
    oam[0] = {8'd250, 24'h010203};
    run_scan(8'd5, 1'b0, -1, -1, "t4e");
    chk("t4e/lit_count", 32'(bus.sprite_count), 32'h0);

    // Start while busy is ignored; reset mid-scan aborts; then a clean scan.
    setup_t2();
    run_scan(8'd12, 1'b0, 20, -1, "t5a");
    run_scan(8'd12, 1'b0, -1, 30, "t5b");
    run_scan(8'd12, 1'b0, -1, -1, "t5c");

    // Full list, start poked in the DONE cycle, then a back-to-back sparse line.
    setup_t3();
    run_scan(8'd50, 1'b0, 22, -1, "t6a");
    setup_t2();
    run_scan(8'd12, 1'b0, -1, -1, "t6b");
    lit_list("t6b/lit_list1", 1, 32'h0);
    chk("t6b/lit_count", 32'(bus.sprite_count), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
